packer: RTL and testbench

Downstream neighbour of the bit-compaction shifter in the logic-analyzer sample path. Each incoming sample carries `cfg_width` meaningful bits in its LSBs; the rest are don't-care. The block concatenates these narrow samples into dense `DW`-bit words for the memory/transmit stage, with the first sample in the LSBs. It supports output backpressure, an explicit flush of a partial word, a synchronous clear, and a combinational bypass when disabled.

---
 rtl/packer.sv | 104 ++++++++++
 tb/tb_packer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packer.sv
// packer: concatenates cfg_width-bit samples, first sample in the LSBs, into
// dense DW-bit words. Supports output backpressure, partial-word flush, clear and bypass.
module packer #(
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctl_clr,
  input  logic                  ctl_ena,
  input  logic                  ctl_flush,
  input  logic [$clog2(DW):0]   cfg_width,
  input  logic                  sti_valid,
  output logic                  sti_ready,
  input  logic [DW-1:0]         sti_data,
  output logic                  sto_valid,
  input  logic                  sto_ready,
  output logic [DW-1:0]         sto_data
);

  localparam int CW = $clog2(DW) + 1;
  localparam int NW = $clog2(DW);
  localparam logic [CW:0] LP_DW = DW[CW:0];

  logic [DW-1:0]   r_acc;
  logic [NW-1:0]   r_cnt;
  logic [DW-1:0]   r_obuf;
  logic            r_ovld;

  logic [CW-1:0]   w_width;
  logic [DW-1:0]   w_mask;
  logic [DW-1:0]   w_sample;
  logic [2*DW-1:0] w_cat;
  logic [CW:0]     w_sum;
  logic            w_full;
  logic [NW-1:0]   w_cnt_nxt;
  logic            w_slot_free;
  logic            w_in_xfer;
  logic            w_flush_go;

  // A width of 0 means a full DW-bit sample; out-of-range widths clamp to DW.
  always_comb begin
    w_width = cfg_width;
    if (cfg_width == '0 || cfg_width > LP_DW[CW-1:0]) begin
      w_width = LP_DW[CW-1:0];
    end
  end

  always_comb begin
    w_mask = '1;
    if (w_width != LP_DW[CW-1:0]) begin
      w_mask = (DW'(1) << w_width) - DW'(1);
    end
  end

  assign w_sample  = sti_data & w_mask;
  // acc is zero above cnt, so an OR places the sample without disturbing it.
  assign w_cat     = ({{DW{1'b0}}, w_sample} << r_cnt) | {{DW{1'b0}}, r_acc};
  assign w_sum     = {2'b00, r_cnt} + {1'b0, w_width};
  assign w_full    = (w_sum >= LP_DW);
  assign w_cnt_nxt = NW'(w_full ? (w_sum - LP_DW) : w_sum);

  assign w_slot_free = !r_ovld || sto_ready;
  assign sti_ready   = ctl_ena ? (!ctl_flush && w_slot_free) : sto_ready;
  assign w_in_xfer   = ctl_ena && sti_valid && sti_ready;
  assign w_flush_go  = ctl_ena && ctl_flush && (r_cnt != '0) && w_slot_free;

  assign sto_valid = ctl_ena ? r_ovld : sti_valid;
  assign sto_data  = ctl_ena ? r_obuf : sti_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_obuf <= '0;
      r_ovld <= 1'b0;
    end else if (ctl_clr) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_obuf <= '0;
      r_ovld <= 1'b0;
    end else if (ctl_ena) begin
      if (w_in_xfer) begin
        r_cnt <= w_cnt_nxt;
        if (w_full) begin
          // Drain and reload may coincide: ovld stays high with no bubble.
          r_obuf <= w_cat[DW-1:0];
          r_ovld <= 1'b1;
          r_acc  <= w_cat[2*DW-1:DW];
        end else begin
          r_acc  <= w_cat[DW-1:0];
          r_ovld <= r_ovld && !sto_ready;
        end
      end else if (w_flush_go) begin
        r_obuf <= r_acc;
        r_ovld <= 1'b1;
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (sto_ready) begin
        r_ovld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packer.sv
// Testbench for packer: directed scenarios plus random traffic, checked by a
// bit-queue reference model feeding a word scoreboard drained by a monitor.
module tb_packer;

  localparam int DW = 32;
  localparam int CW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ctl_clr = 1'b0;
  logic          ctl_ena = 1'b1;
  logic          ctl_flush = 1'b0;
  logic [CW-1:0] cfg_width = 6'd8;
  logic          sti_valid = 1'b0;
  logic          sti_ready;
  logic [DW-1:0] sti_data = '0;
  logic          sto_valid;
  logic          sto_ready = 1'b1;
  logic [DW-1:0] sto_data;

  int n_checks = 0;
  int n_err = 0;

  bit            bits[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  packer #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl_clr   (ctl_clr),
    .ctl_ena   (ctl_ena),
    .ctl_flush (ctl_flush),
    .cfg_width (cfg_width),
    .sti_valid (sti_valid),
    .sti_ready (sti_ready),
    .sti_data  (sti_data),
    .sto_valid (sto_valid),
    .sto_ready (sto_ready),
    .sto_data  (sto_data)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a stream of bits, cut into DW-bit words as it fills.
  function automatic void model_push(input logic [DW-1:0] d);
    int w;
    logic [DW-1:0] word;
    w = (cfg_width == 0) ? DW : int'(cfg_width);
    for (int i = 0; i < w; i++) bits.push_back(d[i]);
    while (bits.size() >= DW) begin
      for (int i = 0; i < DW; i++) word[i] = bits.pop_front();
      exp_q.push_back(word);
    end
  endfunction

  function automatic void model_flush();
    logic [DW-1:0] word;
    if (bits.size() > 0) begin
      word = '0;
      for (int i = 0; i < bits.size(); i++) word[i] = bits[i];
      bits.delete();
      exp_q.push_back(word);
    end
  endfunction

  // One cycle of stimulus; returns at the following falling edge.
  // Flush cycles are always issued with sto_ready=1 so the output slot is free.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy,
                      input logic fl, input logic clr, output logic acc);
    @(posedge clk);
    #1;
    sti_valid = v;
    sti_data  = d;
    sto_ready = rdy;
    ctl_flush = fl;
    ctl_clr   = clr;
    @(negedge clk);
    acc = ctl_ena && sti_valid && sti_ready && !ctl_clr;
    if (clr) bits.delete();
    else if (fl) model_flush();
    else if (acc) model_push(d);
  endtask

  task automatic idle();
    logic a;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic rdy);
    logic a;
    int tries;
    tries = 0;
    do begin
      step(1'b1, d, rdy, 1'b0, 1'b0, a);
      tries++;
    end while (!a && tries < 50);
    if (!a) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: sample %h not accepted, got none expected accept", d);
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer, checks stall stability
  // and the input-ready rule in packing mode.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst_n && ctl_ena) begin
      if (prev_stall) begin
        check("stall_valid", {31'b0, sto_valid}, 32'd1);
        check("stall_data", sto_data, prev_data);
      end
      check("ready_rule", {31'b0, sti_ready},
            {31'b0, !ctl_flush && (!sto_valid || sto_ready)});
      if (sto_valid && sto_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_word: got %h expected no word", sto_data);
        end else begin
          check("word", sto_data, exp_q.pop_front());
        end
      end
      prev_stall = sto_valid && !sto_ready;
      prev_data  = sto_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic a;
    int   cyc;
    int   guard;

    // Reset values
    #3;
    check("rst_valid", {31'b0, sto_valid}, 32'd0);
    check("rst_data", sto_data, 32'd0);
    check("rst_ready", {31'b0, sti_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Width 8 with garbage upper bits
    cfg_width = 6'd8;
    send(32'hFFFFFF11, 1'b1);
    send(32'hFFFFFF22, 1'b1);
    send(32'hFFFFFF33, 1'b1);
    send(32'hFFFFFF44, 1'b1);
    check("w8_before", {31'b0, sto_valid}, 32'd0);
    idle();
    check("w8_valid", {31'b0, sto_valid}, 32'd1);
    check("w8_data", sto_data, 32'h44332211);
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, a);
    check("flush_blocks0", {31'b0, sti_ready}, 32'd0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    idle();
    check("empty_flush", {31'b0, sto_valid}, 32'd0);

    // Width 12 split word, then flush the 4-bit remainder
    cfg_width = 6'd12;
    send(32'h00000ABC, 1'b1);
    send(32'h00000123, 1'b1);
    send(32'h00000456, 1'b1);
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, a);
    check("flush_blocks", {31'b0, sti_ready}, 32'd0);
    check("w12_data", sto_data, 32'h56123ABC);
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, a);
    check("flush_valid", {31'b0, sto_valid}, 32'd1);
    check("flush_data", sto_data, 32'h00000004);
    idle();
    check("flush_once", {31'b0, sto_valid}, 32'd0);

    // Width 32 with a 3-cycle stall mid-stream
    cfg_width = 6'd32;
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      a = 1'b0;
      guard = 0;
      while (!a && guard < 20) begin
        step(1'b1, 32'hA0 + i, !(cyc >= 2 && cyc < 5), 1'b0, 1'b0, a);
        if (cyc >= 2 && cyc < 5) check("bp_ready", {31'b0, sti_ready}, 32'd0);
        cyc++;
        guard++;
      end
    end
    idle();
    idle();
    check("bp_cycles", cyc, 32'd9);

    // Clear discards a partial word
    cfg_width = 6'd8;
    send(32'h11, 1'b1);
    send(32'h22, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, a);
    send(32'h33, 1'b1);
    send(32'h44, 1'b1);
    send(32'h55, 1'b1);
    send(32'h66, 1'b1);
    idle();
    check("clr_data", sto_data, 32'h66554433);
    idle();

    // Asynchronous reset with a held word and 16 pending bits
    cfg_width = 6'd24;
    send(32'hAAAAAA, 1'b0);
    send(32'hBBBBBB, 1'b0);
    idle();
    sto_ready = 1'b0;
    check("pre_rst_valid", {31'b0, sto_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, sto_valid}, 32'd0);
    check("async_rst_data", sto_data, 32'd0);
    bits.delete();
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    cfg_width = 6'd8;
    send(32'h01, 1'b1);
    send(32'h02, 1'b1);
    send(32'h03, 1'b1);
    send(32'h04, 1'b1);
    idle();
    check("post_rst_data", sto_data, 32'h04030201);
    idle();

    // Bypass keeps the accumulator intact
    send(32'h11, 1'b1);
    send(32'h22, 1'b1);
    @(posedge clk);
    #1;
    ctl_ena   = 1'b0;
    sti_valid = 1'b1;
    sti_data  = 32'hDEADBEEF;
    sto_ready = 1'b0;
    #1;
    check("byp_valid", {31'b0, sto_valid}, 32'd1);
    check("byp_data", sto_data, 32'hDEADBEEF);
    check("byp_ready0", {31'b0, sti_ready}, 32'd0);
    sto_ready = 1'b1;
    #1;
    check("byp_ready1", {31'b0, sti_ready}, 32'd1);
    @(posedge clk);
    #1;
    sti_data = 32'hCAFEF00D;
    #1;
    check("byp_data2", sto_data, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    sti_valid = 1'b0;
    ctl_ena   = 1'b1;
    send(32'h33, 1'b1);
    send(32'h44, 1'b1);
    idle();
    check("byp_resume", sto_data, 32'h44332211);
    idle();

    // Randomized traffic over random widths (0 meaning full width)
    for (int b = 0; b < 10; b++) begin
      idle();
      idle();
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, a);
      cfg_width = 6'($urandom_range(0, 32));
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 15) == 0) begin
          step(1'($urandom), $urandom, 1'b1, 1'b1, 1'b0, a);
          step(1'($urandom), $urandom, 1'b1, 1'b1, 1'b0, a);
        end else begin
          step(1'($urandom_range(0, 3) != 0), $urandom,
               1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, a);
        end
      end
      step(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      idle();
      guard++;
    end
    check("leftover_words", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
